// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer of {parity_error, data} entries with count, status, sticky overrun and flush.
// Optional registered almost_full output when UART_RX_FIFO_ALMOST_FULL_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_parity_error,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_parity_error,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  output logic                     almost_full,
`endif
  input  logic                     overrun_clr,
  input  logic                     flush
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_param
    $error("uart_rx_fifo: illegal DEPTH/AF_THRESH");
  end
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_nxt;
  logic                do_wr, do_rd, ovr_set;
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  // a read on a full FIFO frees the slot the simultaneous write lands in
  assign do_wr     = wr_en & ~flush & (~full | rd_en);
  assign do_rd     = rd_en & ~flush & ~empty;
  assign ovr_set   = wr_en & full & ~rd_en & ~flush;
  assign count_nxt = flush ? '0 : count + CW'(do_wr) - CW'(do_rd);
  assign {rd_parity_error, rd_data} = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= {wr_parity_error, wr_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      almost_full <= 1'b0;
`endif
    end else begin
      wr_ptr  <= flush ? '0 : wr_ptr + AW'(do_wr);
      rd_ptr  <= flush ? '0 : rd_ptr + AW'(do_rd);
      count   <= count_nxt;
      overrun <= ovr_set | (overrun & ~overrun_clr);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      almost_full <= count_nxt >= CW'(AF_THRESH);
`endif
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench; stimulus pushes accepted entries, a negedge monitor checks every pop.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_en = 1'b0, wr_parity_error = 1'b0, rd_en = 1'b0, overrun_clr = 1'b0, flush = 1'b0;
  logic [7:0] wr_data = '0, rd_data;
  logic       rd_parity_error, empty, full, overrun;
  logic [4:0] count;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif
  int checks = 0, errors = 0;
  int m_cnt = 0;
  logic m_ovr = 1'b0;
  logic [8:0] exp_q [$];

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8), .AF_THRESH(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_parity_error(wr_parity_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_parity_error(rd_parity_error), .empty(empty), .full(full),
    .count(count), .overrun(overrun),
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .overrun_clr(overrun_clr), .flush(flush));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every accepted pop must present the oldest expected entry
  always @(negedge clk)
    if (rst_n && rd_en && !empty && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry", {rd_parity_error, rd_data});
      end else chk("pop_data", {23'd0, rd_parity_error, rd_data}, {23'd0, exp_q.pop_front()});
    end

  task automatic cyc(input logic wr, input logic [7:0] d, input logic pe, input logic rd,
                     input logic fl = 1'b0, input logic oc = 1'b0);
    logic acc_wr, acc_rd;
    wr_en = wr; wr_data = d; wr_parity_error = pe; rd_en = rd; flush = fl; overrun_clr = oc;
    acc_wr = wr && !fl && (m_cnt < DEPTH || rd);
    acc_rd = rd && !fl && m_cnt > 0;
    if (acc_wr) exp_q.push_back({pe, d});
    m_ovr = (wr && !fl && !rd && m_cnt == DEPTH) || (m_ovr && !oc);
    m_cnt = fl ? 0 : m_cnt + int'(acc_wr) - int'(acc_rd);
    if (fl) exp_q.delete();
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
    chk("count", count, m_cnt);
    chk("empty", empty, m_cnt == 0);
    chk("full", full, m_cnt == DEPTH);
    chk("overrun", overrun, m_ovr);
    chk("head", {23'd0, rd_parity_error, rd_data}, m_cnt == 0 ? 0 : {23'd0, exp_q[0]});
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    chk("almost_full", almost_full, m_cnt >= 12);
`endif
  endtask

  task automatic pop_all();
    while (m_cnt > 0) cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_pe", rd_parity_error, 0);
    chk("rst_overrun", overrun, 0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    chk("rst_af", almost_full, 0);
`endif
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rd_empty_ignored", count, 0);
    // basic FWFT
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    chk("t2_data", rd_data, 8'h41);
    chk("t2_pe", rd_parity_error, 0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_data2", rd_data, 8'h5A);
    chk("t2_pe2", rd_parity_error, 1);
    chk("t2_cnt", count, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_empty", empty, 1);
    // overrun
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t3_full", full, 1);
    chk("t3_cnt", count, 16);
    chk("t3_ovr", overrun, 1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_set_wins", overrun, 1);
    pop_all();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", overrun, 0);
    // simultaneous read/write at full and empty
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    chk("t4_cnt", count, 16);
    chk("t4_ovr", overrun, 0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_last", rd_data, 8'hAA);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h33, 1'b0, 1'b1);
    chk("t4_cnt1", count, 1);
    chk("t4_data", rd_data, 8'h33);
    pop_all();
    // flush beats write
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("t5_cnt", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_ovr", overrun, 0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("t5_data", rd_data, 8'h77);
    pop_all();
    // streaming through several pointer wraps
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h80 + i), i[0], 1'b1);
    pop_all();
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b1);
    pop_all();
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t6_af11", almost_full, 0);
    cyc(1'b1, 8'h0B, 1'b0, 1'b0);
    chk("t6_af12", almost_full, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_af_pop", almost_full, 0);
    cyc(1'b1, 8'h0C, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_af_flush", almost_full, 0);
`endif
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
